vu_meter_multi: RTL and testbench
=================================

// Module: vu_meter_multi
// PURPOSE
//  Parametrised multi-channel LED level meter for the audio path. Per channel: decimates
//  signed samples, rectifies them, keeps a moving average over a circular window, and drives
//  a thermometer LED bar with instant attack and timed decay. Sits between the audio front
//  end and the labkit LED/display drivers.
// PARAMETERS
//  NCH          2       number of channels
//  SAMPLE_W     18      signed sample width per channel
//  LEDS         30      LEDs per channel bar
//  WIN_LOG2     5       moving-average window depth = 2**WIN_LOG2 entries
//  DECIM        49      accept one sample per DECIM valid strobes (>=1)
//  DECAY_TICKS  65536   clocks between one-LED decay steps (>=1)
//  HOLD_TICKS   2**22   peak-hold time in clocks (PEAK_HOLD_EN only)
// PORTS
//  clock         in   1              system clock
//  reset         in   1              synchronous, active-high
//  sample_valid  in   1              one-cycle strobe, all channels sampled together
//  sample_data   in   NCH*SAMPLE_W   ch k at [k*SAMPLE_W +: SAMPLE_W], two's complement
//  bar           out  NCH*LEDS       ch k at [k*LEDS +: LEDS]; bit i lit iff i < level
//  level         out  NCH*LVL_W      displayed level 0..LEDS, LVL_W = clog2(LEDS+1)
//  peak_level    out  NCH*LVL_W      held peak 0..LEDS (0 when PEAK_HOLD_EN undefined)
// BEHAVIOUR
//  - Reset: bar, level, peak_level, sums, fill/write pointers, decim and decay counters = 0.
//    Reset mid-operation clears everything next edge; window RAM is not cleared (see fill).
//  - Decimation: dec_cnt counts valid strobes 0..DECIM-1; the strobe seen at DECIM-1 is
//    accepted and dec_cnt wraps to 0. DECIM=1 accepts every strobe.
//  - Rectify: mag = |x|, width SAMPLE_W-1; most-negative value saturates to 2**(SAMPLE_W-1)-1.
//  - Window: circular buffer, wr_ptr wraps at 2**WIN_LOG2. On accept (cycle N):
//    sum <= sum + mag - old; old reads as 0 while fill < 2**WIN_LOG2 (fill saturates).
//    sum width SAMPLE_W-1+WIN_LOG2, never overflows.
//  - Target (cycle N+1): avg = sum >> WIN_LOG2; target = (avg*LEDS) >> (SAMPLE_W-1),
//    clamped to LEDS. Full-precision product, truncation toward zero.
//  - Display (cycle N+2): if target >= level, level <= target (attack, immediate);
//    else on each decay tick level <= level-1 until it equals target. Attack beats a
//    simultaneous decay tick. Decay tick: shared free-running counter wraps at DECAY_TICKS.
//  - bar is a registered decode of level, updated same edge as level.
//  - Channels fully independent except shared dec_cnt and decay tick.
// CONFIGURATION
//  PEAK_HOLD_EN defined: per channel, if level > peak, peak <= level and hold_cnt <=
//    HOLD_TICKS-1; else hold_cnt decrements per clock to 0; at 0 peak drops one per decay
//    tick, never below level. bar additionally lights bit peak-1 when peak > 0.
//  PEAK_HOLD_EN undefined: no peak logic; peak_level tied 0; bar is pure thermometer.
// STRUCTURE
//  - Shared package vu_pkg: clog2 function, LVL_W/SUM_W derivations, abs-saturate and
//    thermometer-decode functions.
//  - Sub-module vu_channel (one per channel via generate): window RAM, running sum, target
//    scaling, level/peak registers. Top holds dec_cnt, decay counter, port slicing.
// TESTING (bench params: NCH=2, SAMPLE_W=18, LEDS=30, WIN_LOG2=2, DECIM=1, DECAY_TICKS=4)
//  - Ch0 +131071 x4 strobes -> level0=29, bar0=30'h1FFFFFFF; ch1 at 0 -> level1=0.
//  - Ch0 -131072 x4 -> saturated mag, level0=29 (same as +full scale).
//  - Reset, one strobe 65536 -> sum=65536, avg=16384, level0=3 at N+2; 3 more -> level0=15.
//  - After level0=29, feed 0s -> target falls; level0 steps down exactly 1 per 4 clocks to 0.
//  - DECIM=3: 6 strobes of 131071 -> only strobes 3,6 accepted (fill=2); reset mid-stream
//    -> all outputs 0 next edge, dec_cnt restarts.
//  - PEAK_HOLD_EN, HOLD_TICKS=8: burst to 29 then silence -> peak_level0 holds 29 for 8
//    clocks, then decays 1 per tick, never below level0; bar bit 28 lit while held.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared helpers for the multi-channel VU meter: width derivations,
// rectifier and bar decode. Optional peak hold is enabled by PEAK_HOLD_EN.
package vu_pkg;

   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int lvl_w(input int unsigned leds);
      return clog2(leds + 1);
   endfunction

   function automatic int sum_w(input int unsigned sw, input int unsigned wl);
      return int'(sw) - 1 + int'(wl);
   endfunction

   // |x| for a w-bit sample; the most negative value saturates
   function automatic logic [63:0] abs_sat(input logic signed [63:0] x,
                                           input int unsigned w);
      logic signed [63:0] lo;
      lo = -(64'sd1 <<< (w - 1));
      if (x == lo) abs_sat = (64'd1 << (w - 1)) - 64'd1;
      else if (x < 0) abs_sat = 64'(-x);
      else abs_sat = 64'(x);
   endfunction

   function automatic logic [63:0] thermo(input int unsigned lvl,
                                          input int unsigned n);
      logic [63:0] t;
      t = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         t[i] = (i < lvl) && (i < n);
      end
      return t;
   endfunction

endpackage

// File: rtl/vu_channel.sv
// One meter channel: rectify, windowed average, scale, attack/decay level.
// Peak hold and its bar marker exist only when PEAK_HOLD_EN is defined.
module vu_channel
   import vu_pkg::*;
#(
   parameter int SAMPLE_W   = 18,
   parameter int LEDS       = 30,
   parameter int WIN_LOG2   = 5,
   parameter int HOLD_TICKS = 4194304
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      accept,
   input  logic                      decay_tick,
   input  logic [SAMPLE_W-1:0]       sample,
   output logic [LEDS-1:0]           bar,
   output logic [lvl_w(LEDS)-1:0]    level,
   output logic [lvl_w(LEDS)-1:0]    peak_level
);

   localparam int MAG_W  = SAMPLE_W - 1;
   localparam int DEPTH  = 1 << WIN_LOG2;
   localparam int SUM_W  = sum_w(SAMPLE_W, WIN_LOG2);
   localparam int LVL_W  = lvl_w(LEDS);
   localparam int PROD_W = MAG_W + LVL_W;

   logic [MAG_W-1:0]    win [DEPTH];
   logic [WIN_LOG2-1:0] wr_ptr;
   logic [WIN_LOG2:0]   fill;
   logic [SUM_W-1:0]    sum;
   logic [MAG_W-1:0]    mag;
   logic [MAG_W-1:0]    old;
   logic [MAG_W-1:0]    avg;
   logic [LVL_W-1:0]    scaled;
   logic [LVL_W-1:0]    target_nxt;
   logic [LVL_W-1:0]    target;
   logic [LVL_W-1:0]    level_q;
   logic [LVL_W-1:0]    level_nxt;
   logic [LEDS-1:0]     bar_q;
   logic [LEDS-1:0]     bar_nxt;

   assign mag = MAG_W'(abs_sat(64'(signed'(sample)), SAMPLE_W));
   // fill saturates at DEPTH, so its top bit marks a full window
   assign old = fill[WIN_LOG2] ? win[wr_ptr] : '0;
   assign avg = sum[SUM_W-1:WIN_LOG2];
   assign scaled = LVL_W'((PROD_W'(avg) * PROD_W'(LEDS)) >> MAG_W);
   assign target_nxt = (scaled > LVL_W'(LEDS)) ? LVL_W'(LEDS) : scaled;

   always_ff @(posedge clock) begin
      if (accept) win[wr_ptr] <= mag;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         fill   <= '0;
         sum    <= '0;
      end else if (accept) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (!fill[WIN_LOG2]) fill <= fill + 1'b1;
         sum <= sum + SUM_W'(mag) - SUM_W'(old);
      end
   end

   always_comb begin
      level_nxt = level_q;
      if (target >= level_q) level_nxt = target;
      else if (decay_tick) level_nxt = level_q - 1'b1;
   end

`ifdef PEAK_HOLD_EN
   localparam int HOLD_W = clog2(HOLD_TICKS + 1);

   logic [LVL_W-1:0]  peak_q;
   logic [LVL_W-1:0]  peak_nxt;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_nxt;

   always_comb begin
      peak_nxt = peak_q;
      hold_nxt = hold_q;
      if (level_q > peak_q) begin
         peak_nxt = level_q;
         hold_nxt = HOLD_W'(HOLD_TICKS - 1);
      end else if (hold_q != '0) begin
         hold_nxt = hold_q - 1'b1;
      end else if (decay_tick && (peak_q > level_q)) begin
         peak_nxt = peak_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         peak_q <= '0;
         hold_q <= '0;
      end else begin
         peak_q <= peak_nxt;
         hold_q <= hold_nxt;
      end
   end

   always_comb begin
      bar_nxt = LEDS'(thermo(32'(level_nxt), LEDS));
      if (peak_nxt != '0) bar_nxt[peak_nxt - 1'b1] = 1'b1;
   end

   assign peak_level = peak_q;
`else
   always_comb begin
      bar_nxt = LEDS'(thermo(32'(level_nxt), LEDS));
   end

   assign peak_level = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         target  <= '0;
         level_q <= '0;
         bar_q   <= '0;
      end else begin
         target  <= target_nxt;
         level_q <= level_nxt;
         bar_q   <= bar_nxt;
      end
   end

   assign level = level_q;
   assign bar   = bar_q;

endmodule

// File: rtl/vu_meter_multi.sv
// Multi-channel LED level meter: shared decimator and decay timebase,
// one vu_channel per channel. Peak hold is enabled by PEAK_HOLD_EN.
module vu_meter_multi
   import vu_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int SAMPLE_W    = 18,
   parameter int LEDS        = 30,
   parameter int WIN_LOG2    = 5,
   parameter int DECIM       = 49,
   parameter int DECAY_TICKS = 65536,
   parameter int HOLD_TICKS  = 4194304
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          sample_valid,
   input  logic [NCH*SAMPLE_W-1:0]       sample_data,
   output logic [NCH*LEDS-1:0]           bar,
   output logic [NCH*lvl_w(LEDS)-1:0]    level,
   output logic [NCH*lvl_w(LEDS)-1:0]    peak_level
);

   localparam int LVL_W = lvl_w(LEDS);
   localparam int DC_W  = clog2(DECIM + 1);
   localparam int DT_W  = clog2(DECAY_TICKS + 1);

   logic [DC_W-1:0] dec_cnt;
   logic [DT_W-1:0] dcy_cnt;
   logic            dec_last;
   logic            accept;
   logic            decay_tick;

   assign dec_last   = (dec_cnt == DC_W'(DECIM - 1));
   assign accept     = sample_valid && dec_last;
   assign decay_tick = (dcy_cnt == DT_W'(DECAY_TICKS - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         dec_cnt <= '0;
      end else if (sample_valid) begin
         dec_cnt <= dec_last ? '0 : dec_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) dcy_cnt <= '0;
      else dcy_cnt <= decay_tick ? '0 : dcy_cnt + 1'b1;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      vu_channel #(
         .SAMPLE_W   (SAMPLE_W),
         .LEDS       (LEDS),
         .WIN_LOG2   (WIN_LOG2),
         .HOLD_TICKS (HOLD_TICKS)
      ) u_ch (
         .clock      (clock),
         .reset      (reset),
         .accept     (accept),
         .decay_tick (decay_tick),
         .sample     (sample_data[g*SAMPLE_W +: SAMPLE_W]),
         .bar        (bar[g*LEDS +: LEDS]),
         .level      (level[g*LVL_W +: LVL_W]),
         .peak_level (peak_level[g*LVL_W +: LVL_W])
      );
   end

endmodule

// File: tb/tb_vu_meter_multi.sv
// Directed bench for vu_meter_multi: DECIM=1 and DECIM=3 instances.
// Peak-hold scenario runs only when PEAK_HOLD_EN is defined.
module tb_vu_meter_multi;

   logic        clock = 1'b0;
   logic        reset;
   logic        sample_valid;
   logic [35:0] sample_data;
   logic [59:0] bar;
   logic [9:0]  level;
   logic [9:0]  peak_level;

   logic        reset3;
   logic        valid3;
   logic [35:0] data3;
   logic [59:0] bar3;
   logic [9:0]  level3;
   logic [9:0]  peak3;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   vu_meter_multi #(
      .NCH(2), .SAMPLE_W(18), .LEDS(30), .WIN_LOG2(2),
      .DECIM(1), .DECAY_TICKS(4), .HOLD_TICKS(8)
   ) dut (
      .clock(clock), .reset(reset), .sample_valid(sample_valid),
      .sample_data(sample_data), .bar(bar), .level(level),
      .peak_level(peak_level)
   );

   vu_meter_multi #(
      .NCH(2), .SAMPLE_W(18), .LEDS(30), .WIN_LOG2(2),
      .DECIM(3), .DECAY_TICKS(4), .HOLD_TICKS(8)
   ) dut3 (
      .clock(clock), .reset(reset3), .sample_valid(valid3),
      .sample_data(data3), .bar(bar3), .level(level3),
      .peak_level(peak3)
   );

   task automatic cyc(input logic v, input logic [17:0] d0,
                      input logic [17:0] d1);
      sample_valid = v;
      sample_data  = {d1, d0};
      @(negedge clock);
   endtask

   task automatic cyc3(input logic v, input logic [17:0] d0);
      valid3 = v;
      data3  = {18'd0, d0};
      @(negedge clock);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      cyc(1'b0, 18'd0, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      reset = 1'b0;
   endtask

   task automatic full_burst;
      for (int i = 0; i < 4; i++) cyc(1'b1, 18'h1FFFF, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
   endtask

   task automatic test_reset;
      do_reset();
      total++;
      if (level !== 10'd0) begin
         bad++; $display("FAIL reset_level got=%h want=0", level);
      end
      total++;
      if (bar !== 60'd0) begin
         bad++; $display("FAIL reset_bar got=%h want=0", bar);
      end
      total++;
      if (peak_level !== 10'd0) begin
         bad++; $display("FAIL reset_peak got=%h want=0", peak_level);
      end
      total++;
      if (level3 !== 10'd0 || bar3 !== 60'd0) begin
         bad++; $display("FAIL reset_dut3 got=%h/%h want=0", level3, bar3);
      end
   endtask

   task automatic test_full_scale;
      do_reset();
      full_burst();
      total++;
      if (level[4:0] !== 5'd29) begin
         bad++; $display("FAIL full_level0 got=%0d want=29", level[4:0]);
      end
      total++;
      if (bar[29:0] !== 30'h1FFFFFFF) begin
         bad++; $display("FAIL full_bar0 got=%h want=1fffffff", bar[29:0]);
      end
      total++;
      if (level[9:5] !== 5'd0) begin
         bad++; $display("FAIL full_level1 got=%0d want=0", level[9:5]);
      end
      total++;
      if (bar[59:30] !== 30'd0) begin
         bad++; $display("FAIL full_bar1 got=%h want=0", bar[59:30]);
      end
   endtask

   task automatic test_neg_full;
      do_reset();
      for (int i = 0; i < 4; i++) cyc(1'b1, 18'h20000, 18'h3FFFF);
      cyc(1'b0, 18'd0, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      total++;
      if (level[4:0] !== 5'd29) begin
         bad++; $display("FAIL neg_level0 got=%0d want=29", level[4:0]);
      end
      total++;
      if (level[9:5] !== 5'd0) begin
         bad++; $display("FAIL neg_level1 got=%0d want=0", level[9:5]);
      end
   endtask

   task automatic test_single;
      do_reset();
      cyc(1'b1, 18'd65536, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      total++;
      if (level[4:0] !== 5'd0) begin
         bad++; $display("FAIL single_n1 got=%0d want=0", level[4:0]);
      end
      cyc(1'b0, 18'd0, 18'd0);
      total++;
      if (level[4:0] !== 5'd3) begin
         bad++; $display("FAIL single_n2 got=%0d want=3", level[4:0]);
      end
      total++;
      if (bar[29:0] !== 30'h7) begin
         bad++; $display("FAIL single_bar got=%h want=7", bar[29:0]);
      end
      for (int i = 0; i < 3; i++) cyc(1'b1, 18'd65536, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      cyc(1'b0, 18'd0, 18'd0);
      total++;
      if (level[4:0] !== 5'd15) begin
         bad++; $display("FAIL four_level got=%0d want=15", level[4:0]);
      end
      total++;
      if (bar[29:0] !== 30'h7FFF) begin
         bad++; $display("FAIL four_bar got=%h want=7fff", bar[29:0]);
      end
   endtask

   task automatic test_decay;
      logic [4:0] prev;
      logic [4:0] cur;
      int last;
      do_reset();
      full_burst();
      total++;
      if (level[4:0] !== 5'd29) begin
         bad++; $display("FAIL decay_start got=%0d want=29", level[4:0]);
      end
      prev = 5'd29;
      last = -1;
      for (int c = 0; c < 200 && prev != 5'd0; c++) begin
         cyc(c < 4, 18'd0, 18'd0);
         cur = level[4:0];
         if (cur != prev) begin
            total++;
            if (cur !== prev - 5'd1) begin
               bad++;
               $display("FAIL decay_step got=%0d want=%0d", cur, prev - 5'd1);
            end
            if (last >= 0) begin
               total++;
               if (c - last != 4) begin
                  bad++;
                  $display("FAIL decay_period got=%0d want=4", c - last);
               end
            end
            last = c;
            prev = cur;
         end
      end
      total++;
      if (level[4:0] !== 5'd0) begin
         bad++; $display("FAIL decay_end got=%0d want=0", level[4:0]);
      end
`ifndef PEAK_HOLD_EN
      total++;
      if (bar[29:0] !== 30'd0) begin
         bad++; $display("FAIL decay_bar got=%h want=0", bar[29:0]);
      end
`endif
   endtask

   task automatic test_decim;
      reset3 = 1'b1;
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      reset3 = 1'b0;
      cyc3(1'b1, 18'h1FFFF);
      cyc3(1'b1, 18'h1FFFF);
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      total++;
      if (level3[4:0] !== 5'd0) begin
         bad++; $display("FAIL decim_s2 got=%0d want=0", level3[4:0]);
      end
      cyc3(1'b1, 18'h1FFFF);
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      total++;
      if (level3[4:0] !== 5'd7) begin
         bad++; $display("FAIL decim_s3 got=%0d want=7", level3[4:0]);
      end
      for (int i = 0; i < 3; i++) cyc3(1'b1, 18'h1FFFF);
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      total++;
      if (level3[4:0] !== 5'd14) begin
         bad++; $display("FAIL decim_s6 got=%0d want=14", level3[4:0]);
      end
      cyc3(1'b1, 18'h1FFFF);
      reset3 = 1'b1;
      cyc3(1'b0, 18'd0);
      reset3 = 1'b0;
      total++;
      if (level3 !== 10'd0 || bar3 !== 60'd0 || peak3 !== 10'd0) begin
         bad++;
         $display("FAIL decim_rst got=%h/%h/%h want=0", level3, bar3, peak3);
      end
      cyc3(1'b1, 18'd65536);
      cyc3(1'b1, 18'd65536);
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      total++;
      if (level3[4:0] !== 5'd0) begin
         bad++; $display("FAIL decim_restart got=%0d want=0", level3[4:0]);
      end
      cyc3(1'b1, 18'd65536);
      cyc3(1'b0, 18'd0);
      cyc3(1'b0, 18'd0);
      total++;
      if (level3[4:0] !== 5'd3) begin
         bad++; $display("FAIL decim_after got=%0d want=3", level3[4:0]);
      end
   endtask

`ifdef PEAK_HOLD_EN
   task automatic test_peak;
      int held;
      held = 0;
      do_reset();
      full_burst();
      for (int c = 0; c < 160; c++) begin
         cyc(1'b0, 18'd0, 18'd0);
         total++;
         if (peak_level[4:0] < level[4:0]) begin
            bad++;
            $display("FAIL peak_floor got=%0d want>=%0d",
                     peak_level[4:0], level[4:0]);
         end
         if (peak_level[4:0] == 5'd29) begin
            held++;
            total++;
            if (bar[28] !== 1'b1) begin
               bad++; $display("FAIL peak_bar28 got=%b want=1", bar[28]);
            end
         end
      end
      total++;
      if (held < 8 || held > 11) begin
         bad++; $display("FAIL peak_hold got=%0d want=8..11", held);
      end
      total++;
      if (peak_level[4:0] !== 5'd0 || level[4:0] !== 5'd0) begin
         bad++;
         $display("FAIL peak_end got=%0d/%0d want=0/0",
                  peak_level[4:0], level[4:0]);
      end
   endtask
`else
   task automatic test_peak_off;
      do_reset();
      full_burst();
      total++;
      if (peak_level !== 10'd0) begin
         bad++; $display("FAIL peak_off got=%h want=0", peak_level);
      end
   endtask
`endif

   initial begin
      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      reset3       = 1'b1;
      valid3       = 1'b0;
      data3        = '0;
      @(negedge clock);
      test_reset();
      test_full_scale();
      test_neg_full();
      test_single();
      test_decay();
      test_decim();
`ifdef PEAK_HOLD_EN
      test_peak();
`else
      test_peak_off();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
